// File: rtl/led_bar_pkg.sv
// Shared types and helpers for the LED bar progress sequencer.
// Holds the FSM state encoding, the ivMode bit positions and the bar pattern encoder.
package led_bar_pkg;

  localparam int MAX_LEDS = 16;

  // ivMode bit positions
  localparam int MODE_DIR  = 0;
  localparam int MODE_WRAP = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bar_state_t;

  // Level k lights bits [k-1:0]; lit=0 blanks the whole bar; activeLow flips polarity.
  function automatic logic [MAX_LEDS-1:0] thermo_encode(
    input logic [4:0] level,
    input logic       lit,
    input logic       activeLow
  );
    logic [MAX_LEDS-1:0] pat;
    pat = '0;
    for (int i = 0; i < MAX_LEDS; i++) begin
      if (lit && (5'(i) < level)) pat[i] = 1'b1;
    end
    return activeLow ? ~pat : pat;
  endfunction

endpackage

// File: rtl/led_tick_div.sv
// iCE-qualified modulo-N counter; oTc marks the iCE cycle on which the count wraps.
// iClear is synchronous and acts with or without iCE.
module led_tick_div #(
  parameter int N = 1
) (
  input  logic iClk,
  input  logic iReset,
  input  logic iClear,
  input  logic iCE,
  input  logic iEn,
  output logic oTc
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [CW-1:0] count;

  assign oTc = iCE && iEn && (count == LAST);

  always_ff @(posedge iClk) begin
    if (iReset || iClear) begin
      count <= '0;
    end else if (iCE && iEn) begin
      count <= (count == LAST) ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/led_bar_sequencer.sv
// Thermometer LED bar that fills or drains while the top-level FSM sits in ACTIVE_STATE.
// Handshake-free: iCE qualifies every register update except reset and iClear.
module led_bar_sequencer
  import led_bar_pkg::*;
#(
  parameter int LED_COUNT    = 3,
  parameter int ACTIVE_LOW   = 1,
  parameter int ACTIVE_STATE = 1,
  parameter int STEP_TICKS   = 1,
  parameter int BLINK_TICKS  = 4
) (
  input  logic                               iClk,
  input  logic                               iReset,
  input  logic                               iCE,
  input  logic                               iClear,
  input  logic [1:0]                         ivStateMachine,
  input  logic [1:0]                         ivMode,
  output logic [LED_COUNT-1:0]               ovLED,
  output logic [$clog2(LED_COUNT+1)-1:0]     ovLevel,
  output logic                               oDone
);

  localparam int LW      = $clog2(LED_COUNT + 1);
  localparam int BLINK_N = (BLINK_TICKS > 0) ? BLINK_TICKS : 1;
  localparam logic [LW-1:0]        LEVEL_MAX = LW'(LED_COUNT);
  localparam logic                 ACT_LOW   = (ACTIVE_LOW != 0);
  localparam logic [1:0]           ACT_STATE = 2'(ACTIVE_STATE);
  localparam logic [LED_COUNT-1:0] DARK      = {LED_COUNT{ACT_LOW}};

  bar_state_t           state, stateNext;
  logic [LW-1:0]        level, levelNext;
  logic [LW-1:0]        startLevel, termLevel;
  logic [1:0]           mode, modeNext;
  logic                 phase, phaseNext;
  logic [LED_COUNT-1:0] ledNext;
  logic                 active;
  logic                 stepTc, blinkTc;
  logic                 stepClear, stepEn, blinkClear, blinkEn;

  assign active = (ivStateMachine == ACT_STATE);

  // Step pacing runs only in RUN and only while the active state is present (pause).
  assign stepClear  = iClear || (state != RUN);
  assign stepEn     = (state == RUN) && active;
  assign blinkClear = iClear || (state != DONE);
  assign blinkEn    = (state == DONE);

  led_tick_div #(.N(STEP_TICKS)) uStepDiv (
    .iClk   (iClk),
    .iReset (iReset),
    .iClear (stepClear),
    .iCE    (iCE),
    .iEn    (stepEn),
    .oTc    (stepTc)
  );

  led_tick_div #(.N(BLINK_N)) uBlinkDiv (
    .iClk   (iClk),
    .iReset (iReset),
    .iClear (blinkClear),
    .iCE    (iCE),
    .iEn    (blinkEn),
    .oTc    (blinkTc)
  );

  always_comb begin
    stateNext  = state;
    levelNext  = level;
    modeNext   = mode;
    phaseNext  = phase;
    startLevel = mode[MODE_DIR] ? LEVEL_MAX : '0;
    termLevel  = mode[MODE_DIR] ? '0 : LEVEL_MAX;
    if (iCE) begin
      unique case (state)
        IDLE: begin
          if (active) begin
            modeNext  = ivMode;
            levelNext = ivMode[MODE_DIR] ? LEVEL_MAX : '0;
            stateNext = RUN;
          end
        end
        RUN: begin
          if (stepTc) begin
            // Sitting on the terminal level in RUN only happens in wrap mode.
            if (level == termLevel)   levelNext = startLevel;
            else if (mode[MODE_DIR])  levelNext = level - LW'(1);
            else                      levelNext = level + LW'(1);
            if ((levelNext == termLevel) && !mode[MODE_WRAP]) begin
              stateNext = DONE;
              phaseNext = 1'b1;
            end
          end
        end
        DONE: begin
          if ((BLINK_TICKS > 0) && blinkTc) phaseNext = !phase;
        end
        default: stateNext = IDLE;
      endcase
    end
    // The pattern is built from next-state values so it changes on the same edge as the state.
    ledNext = LED_COUNT'(thermo_encode(5'(levelNext), (stateNext != DONE) || phaseNext, ACT_LOW));
  end

  always_ff @(posedge iClk) begin
    if (iReset || iClear) begin
      state <= IDLE;
      level <= '0;
      mode  <= '0;
      phase <= 1'b1;
      ovLED <= DARK;
      oDone <= 1'b0;
    end else begin
      state <= stateNext;
      level <= levelNext;
      mode  <= modeNext;
      phase <= phaseNext;
      ovLED <= ledNext;
      oDone <= (stateNext == DONE);
    end
  end

  assign ovLevel = level;

  always_ff @(posedge iClk) begin
    if (!iReset) assert (level <= LEVEL_MAX);
  end

endmodule

// File: doc/led_bar_sequencer.md
Name: led_bar_sequencer

Overview:
- Parametrised LED bar progress indicator for the spirometer measurement state.
- Advances a thermometer-coded LED bar while the top-level state machine sits in a configurable state, paced by the system clock-enable tick.
- Adds over the fixed 3-LED indicator: configurable width, step pacing, fill/drain direction, wrap mode, end-of-sequence blink, a done flag and a level readout.
- Sits between the top-level state machine / CE divider and the board LED pins.

Parameters:
- LED_COUNT, 3: number of LEDs in the bar; legal range 1..16.
- ACTIVE_LOW, 1: 1 means LED lit = 0 and dark = 1 on ovLED.
- ACTIVE_STATE, 1: ivStateMachine value that enables sequencing (2 bits).
- STEP_TICKS, 1: iCE pulses per level step; legal range 1..255.
- BLINK_TICKS, 4: iCE pulses per blink half-period in DONE; 0 disables blinking (DONE then holds steady).

Ports:
- iClk  in  1  system clock.
- iReset  in  1  synchronous, active-high reset.
- iCE  in  1  clock-enable tick; one-cycle pulse.
- iClear  in  1  synchronous return to IDLE; acts regardless of iCE.
- ivStateMachine  in  2  top-level state code.
- ivMode  in  2  bit0 = direction (0 fill, 1 drain); bit1 = wrap (1 restart endlessly, 0 stop in DONE).
- ovLED  out  LED_COUNT  bar pattern, polarity per ACTIVE_LOW.
- ovLevel  out  clog2(LED_COUNT+1)  current lit count.
- oDone  out  1  high while in DONE.

Behaviour:
- Reset: state IDLE, level 0, tick counters 0, blink phase on, oDone 0, ovLED all dark (all 1s when ACTIVE_LOW).
- iReset has priority over iClear; iClear has priority over all else. iClear gives the same register values as reset.
- All registers update only on iCE cycles, except reset and iClear.
- Pattern: level k lights bits [k-1:0], LSB first; the rest are dark. In DONE with blink phase off, all LEDs are dark.
- ovLED, ovLevel and oDone are registered. Pattern and state change on the same edge.
- State IDLE:
  - ovLED is dark.
  - On an iCE cycle with ivStateMachine == ACTIVE_STATE: latch ivMode, load level (0 for fill, LED_COUNT for drain), clear the step counter, go to RUN.
  - That first iCE cycle shows the start level; no step is taken on it.
- State RUN:
  - Each iCE cycle with the active state increments the step counter.
  - When the step counter reaches STEP_TICKS-1, it clears and the level moves one step (+1 fill, -1 drain).
  - With STEP_TICKS=1, the level moves on every active iCE.
- End of sequence: when a step lands on the terminal level (LED_COUNT for fill, 0 for drain):
  - Wrap = 0: go to DONE, oDone rises, blink counter clears, phase on.
  - Wrap = 1: the next step reloads the start level instead of going past the terminal level. The sequence is 0,1,..,N,0,1,.. for fill and N,..,0,N,.. for drain. The terminal level is shown for one full step.
- Pause: ivStateMachine != ACTIVE_STATE in RUN freezes level, step counter and pattern; no state change. Resume continues from the frozen values.
- Mode: ivMode changes after the IDLE->RUN transition are ignored until the next IDLE.
- State DONE:
  - Holds the terminal level.
  - If BLINK_TICKS > 0, the blink phase toggles every BLINK_TICKS iCE cycles.
  - DONE is left only via iClear or iReset; ivStateMachine leaving ACTIVE_STATE has no effect.
- Degenerate case, LED_COUNT=1: fill goes 0->1 then DONE.
- Widths: counters saturate-free, sized from parameters; the level never exceeds LED_COUNT or goes below 0 (checked by assertion).

Decomposition:
- Package led_bar_pkg: state enum {IDLE, RUN, DONE}, mode bit-index constants (MODE_DIR=0, MODE_WRAP=1), and a function for thermometer encode with polarity.
- Sub-module led_tick_div: generic iCE-qualified modulo-N counter with a terminal-count pulse. Instantiated twice, for step pacing and blink pacing. The FSM, level register and output register stay in the top module.

Test Plan:
- Reset, default parameters, fill, ivStateMachine=1, iCE every cycle -> ovLED 111,110,100,000 on successive iCE cycles; oDone=1 with 000; holds, since BLINK_TICKS=4 toggles 000/111 every 4 iCE.
- Drain with wrap, STEP_TICKS=2, LED_COUNT=4 -> ovLevel 4,4,3,3,2,2,1,1,0,0,4 at two iCE cycles per level; oDone stays 0.
- Pause: fill, drop ivStateMachine to 2 at level 2 for 10 iCE -> ovLED stays 100 and ovLevel 2; restore -> next active iCE gives 000 then DONE.
- iClear asserted mid-RUN without iCE -> next cycle ovLED 111, ovLevel 0, oDone 0; iReset and iClear together -> reset values.
- ivMode toggled during RUN -> direction unchanged; after iClear the new mode takes effect on restart.
- ACTIVE_LOW=0, LED_COUNT=1, BLINK_TICKS=0 -> ovLED 0 then 1, oDone=1, steady with no blinking over 20 iCE.
